// File: rtl/gpr_wport_arbiter.sv
// Shares the GPR write port between the WB stage (priority) and the long-latency unit.
// LL results are queued in a small FIFO with WAW kill, starvation-bounded via stall_req.
module gpr_wport_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 5,
  parameter int unsigned DW         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DW-1:0]        wb_data,
  input  logic                 ll_valid,
  output logic                 ll_ready,
  input  logic [AW-1:0]        ll_addr,
  input  logic [DW-1:0]        ll_data,
  output logic                 stall_req,
  output logic [(2**AW)-1:0]   pend_mask,
  output logic                 gpr_we,
  output logic [AW-1:0]        gpr_a3,
  output logic [DW-1:0]        gpr_wd
);

  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned AGW = $clog2(STARVE_MAX + 1);
  localparam int unsigned NR  = 2**AW;

  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]         addr_q [FIFO_DEPTH];
  logic [DW-1:0]         data_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_q, wr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [AGW-1:0]        age_q, age_d;
  logic                  ready_q, stall_q;
  logic [NR-1:0]         pend_q, pend_d;

  logic wb_hit, empty, pop, accept, push, head_wr;

  // Request decode; WB always wins, FIFO head drains only on a free port
  always_comb begin
    wb_hit  = wb_we && (wb_addr != '0);
    empty   = (cnt_q == '0);
    pop     = !wb_hit && !empty;
    accept  = ll_valid && ready_q;
    push    = accept && (ll_addr != '0);
    head_wr = pop && vld_q[rd_q];
  end

  // Write-port mux, forced idle while in reset
  always_comb begin
    gpr_we = 1'b0;
    gpr_a3 = '0;
    gpr_wd = '0;
    if (!rst) begin
      if (wb_hit) begin
        gpr_we = 1'b1;
        gpr_a3 = wb_addr;
        gpr_wd = wb_data;
      end else if (head_wr) begin
        gpr_we = 1'b1;
        gpr_a3 = addr_q[rd_q];
        gpr_wd = data_q[rd_q];
      end
    end
  end

  // Next FIFO validity: kill older same-address entries, then pop, then push
  always_comb begin
    vld_d = vld_q;
    if (wb_hit) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (addr_q[i] == wb_addr) vld_d[i] = 1'b0;
      end
    end
    if (pop)  vld_d[rd_q] = 1'b0;
    if (push) vld_d[wr_q] = 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Pending mask reflects the FIFO contents after this edge
  always_comb begin
    pend_d = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_d[i]) begin
        if (push && (wr_q == PW'(i))) pend_d[ll_addr]   = 1'b1;
        else                          pend_d[addr_q[i]] = 1'b1;
      end
    end
  end

  // Head age: only a non-empty, non-popping FIFO is blocked by WB
  always_comb begin
    age_d = age_q;
    if (empty || pop)                    age_d = '0;
    else if (age_q != AGW'(STARVE_MAX))  age_d = age_q + AGW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      age_q   <= '0;
      ready_q <= 1'b0;
      stall_q <= 1'b0;
      pend_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      age_q   <= age_d;
      ready_q <= (cnt_d != CW'(FIFO_DEPTH));
      stall_q <= (age_d == AGW'(STARVE_MAX));
      pend_q  <= pend_d;
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push) wr_q <= wr_q + PW'(1);
    end
  end

  // Payload storage needs no reset; validity bits qualify it
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_q[wr_q] <= ll_addr;
      data_q[wr_q] <= ll_data;
    end
  end

  assign ll_ready  = ready_q;
  assign stall_req = stall_q;
  assign pend_mask = pend_q;

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Directed + random bench for gpr_wport_arbiter against a queue-based reference model.
module tb_gpr_wport_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  logic rst;
  logic wb_we, ll_valid;
  logic [AW-1:0] wb_addr, ll_addr;
  logic [DW-1:0] wb_data, ll_data;
  logic ll_ready, stall_req, gpr_we;
  logic [31:0] pend_mask;
  logic [AW-1:0] gpr_a3;
  logic [DW-1:0] gpr_wd;

  gpr_wport_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
    .stall_req(stall_req), .pend_mask(pend_mask),
    .gpr_we(gpr_we), .gpr_a3(gpr_a3), .gpr_wd(gpr_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            v;
  } ent_t;

  ent_t q[$];
  int   age;
  bit   m_ready, m_stall;
  logic [31:0] m_pend;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend_of_queue();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].v) m[q[i].a] = 1'b1;
    return m;
  endfunction

  // One clock cycle: drive, check comb + registered outputs, advance model, clock
  task automatic cyc(input bit r, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    bit hit, acc, popped, was_empty;
    bit e_we;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd;
    rst = r; wb_we = we; wb_addr = wa; wb_data = wd;
    ll_valid = lv; ll_addr = la; ll_data = ld;
    #2;
    hit = we && (wa != 0);
    e_we = 0; e_a3 = 0; e_wd = 0;
    if (!r) begin
      if (hit) begin
        e_we = 1; e_a3 = wa; e_wd = wd;
      end else if (q.size() > 0 && q[0].v) begin
        e_we = 1; e_a3 = q[0].a; e_wd = q[0].d;
      end
    end
    chk("gpr_we", 64'(gpr_we), 64'(e_we));
    chk("gpr_a3", 64'(gpr_a3), 64'(e_a3));
    chk("gpr_wd", 64'(gpr_wd), 64'(e_wd));
    chk("ll_ready", 64'(ll_ready), 64'(m_ready));
    chk("stall_req", 64'(stall_req), 64'(m_stall));
    chk("pend_mask", 64'(pend_mask), 64'(m_pend));
    if (gpr_we === 1'b1) chk("no_r0_write", 64'(gpr_a3 == 0), 64'd0);
    if (r) begin
      q.delete(); age = 0; m_ready = 0; m_stall = 0; m_pend = '0;
    end else begin
      acc = lv && m_ready;
      was_empty = (q.size() == 0);
      if (hit) foreach (q[i]) if (q[i].a == wa) q[i].v = 0;
      popped = !hit && !was_empty;
      if (popped) void'(q.pop_front());
      if (was_empty || popped) age = 0;
      else if (age < SMAX) age++;
      if (acc && la != 0) q.push_back('{a: la, d: ld, v: 1'b1});
      m_ready = (q.size() < DEPTH);
      m_stall = (age == SMAX);
      m_pend  = pend_of_queue();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    bit w, l;
    rst = 1; wb_we = 0; wb_addr = 0; wb_data = 0; ll_valid = 0; ll_addr = 0; ll_data = 0;
    q.delete(); age = 0; m_ready = 0; m_stall = 0; m_pend = '0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle();
    chk("ready_after_reset", 64'(ll_ready), 64'd1);

    // WB write with FIFO empty goes straight through
    cyc(0, 1, 5, 32'h0000_1234, 0, 0, 0);

    // LL result with free port: one-cycle latency, pend bit for one cycle
    cyc(0, 0, 0, 0, 1, 7, 32'hAAAA_5555);
    chk("pend7_set", 64'(pend_mask), 64'h80);
    idle();
    chk("pend7_clear", 64'(pend_mask), 64'h0);

    // Two LL results starved by continuous WB traffic
    cyc(0, 1, 10, 32'h10, 1, 3, 32'h3333);
    cyc(0, 1, 11, 32'h11, 1, 4, 32'h4444);
    chk("full_not_ready", 64'(ll_ready), 64'd0);
    guard = 0;
    while (!m_stall && guard < 20) begin
      cyc(0, 1, 12, 32'h12, 0, 0, 0);
      guard++;
    end
    chk("starve_bound", 64'(guard <= SMAX), 64'd1);
    chk("stall_up", 64'(stall_req), 64'd1);
    idle();
    chk("stall_down", 64'(stall_req), 64'd0);
    idle();
    idle();

    // WAW kill: buffered r9 superseded by younger WB write
    cyc(0, 0, 0, 0, 1, 9, 32'h11);
    cyc(0, 1, 9, 32'h22, 0, 0, 0);
    chk("pend9_killed", 64'(pend_mask), 64'h0);
    idle();
    idle();

    // Register-0 requests are suppressed on both sides
    cyc(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    chk("r0_pend", 64'(pend_mask), 64'h0);
    chk("r0_ready", 64'(ll_ready), 64'd1);
    idle();

    // Reset with two buffered entries discards them
    cyc(0, 1, 1, 32'h1, 1, 2, 32'h2);
    cyc(0, 1, 1, 32'h1, 1, 6, 32'h6);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pend", 64'(pend_mask), 64'h0);
    chk("rst_ready", 64'(ll_ready), 64'd0);
    idle();
    idle();

    // Random traffic honouring the bubble contract on stall_req
    for (int k = 0; k < 400; k++) begin
      w = ($urandom_range(0, 99) < 55) && !m_stall;
      l = ($urandom_range(0, 99) < 45);
      cyc(($urandom_range(0, 199) == 0), w, AW'($urandom_range(0, 7)), $urandom(),
          l, AW'($urandom_range(0, 7)), $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
